taxi_axi_pipe_rd: RTL and testbench
===================================

# taxi_axi_pipe_rd

AXI4 read-path register slice: inserts a configurable register stage on the AR channel (master-bound) and the R channel (slave-bound) between an upstream AXI4 read master and a downstream read slave. Breaks timing paths in both directions without changing transaction content, ordering or ID. Sits on long interconnect hops, between crossbar ports and memory controllers; companion to the write-side tie/pipe blocks.

## Interface
- AR_REG_TYPE, 2: AR stage type. 0 = bypass (wires), 1 = simple register, 2 = skid buffer.
- R_REG_TYPE, 2: R stage type, same encoding.
- clk  input  1  clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- s_axi_rd  taxi_axi_if.rd_slv  —  upstream read slave port (AR in, R out).
- m_axi_rd  taxi_axi_if.rd_mst  —  downstream read master port (AR out, R in).
- DATA_W, ADDR_W, ID_W, ARUSER_W, RUSER_W taken from s_axi_rd; $fatal at elaboration if m_axi_rd DATA_W, ADDR_W or ID_W differs, or if a REG_TYPE is outside 0..2.

## Operation
- AR payload: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser. R payload: rid, rdata, rresp, rlast, ruser. Payload carried unmodified; no reordering, no merging, no splitting.
- Type 0: output valid/payload = input; input ready = output ready; no flops.
- Type 1 (simple register): one output register. Input ready = !out_valid. Accept loads out register; out_valid clears when output handshakes. Max throughput 1 beat per 2 cycles; all paths registered.
- Type 2 (skid buffer): output register plus one temp register. Input ready = registered, = !temp_valid. States: EMPTY (out invalid), ONE (out valid, temp empty), FULL (both valid).
  - EMPTY + in handshake -> ONE.
  - ONE + in handshake, no out handshake -> FULL (beat to temp).
  - ONE + in and out handshake same cycle -> ONE (in beat to out reg).
  - ONE + out handshake only -> EMPTY.
  - FULL + out handshake -> ONE (temp moves to out); no input accepted in FULL.
- Payload registers not reset; only valid bits reset.
- Reset mid-burst: all valid bits clear, buffered beats discarded; upstream/downstream must also be reset (no transaction recovery).

## Timing
- Reset values: m_axi_rd.arvalid = 0, s_axi_rd.rvalid = 0; s_axi_rd.arready = 1 and m_axi_rd.rready = 1 for types 1/2 (type 0 follows the opposite side).
- Latency: types 1/2 exactly 1 cycle from input handshake to output valid.
- Type 2 sustains 1 beat/cycle with continuous ready; output stall of N cycles absorbs exactly 1 extra beat, then input ready deasserts the next cycle.
- Valid never drops without handshake; payload stable while valid && !ready.
- No combinational path input -> output for types 1/2 (valid, ready, or payload).

## Configuration
- TAXI_AXI_PIPE_RD_USER_EN defined: aruser and ruser registered and forwarded when both interfaces enable ARUSER_EN/RUSER_EN respectively.
- Undefined: no user flops; m_axi_rd.aruser and s_axi_rd.ruser driven to '0 regardless of interface enables.

## Structure
- taxi_axi_pkg: REG_TYPE constants (BYPASS=0, SIMPLE=1, SKID=2) and skid state enum.
- Sub-module taxi_axi_pipe_rd_ch: generic valid/ready stage, parameters REG_TYPE and W; instanced once for AR (concatenated payload) and once for R.

## Test plan
- Reset with rst_n low mid-traffic -> arvalid=0, rvalid=0 asynchronously; arready=1 first cycle after release (type 2).
- Type 2, 16 AR beats back-to-back, m arready=1 -> all 16 on output, 1-cycle latency, 16 consecutive cycles, IDs/addresses 0x1000+64*i unchanged.
- Type 2, R burst arlen=7 (8 beats, rid=5), rready low 3 cycles mid-burst -> exactly one beat skidded, s rready... m rready drops one cycle later, no beat lost/duplicated, rlast only on beat 8.
- Type 1, continuous traffic -> 1 beat every 2 cycles, data intact.
- Type 0 -> outputs equal inputs same cycle, zero flops in that channel.
- Macro undefined, aruser=0x3 driven -> m aruser=0; macro defined -> 0x3 forwarded.

Source files
------------

// File: rtl/taxi_axi_pkg.sv
// Shared definitions for the taxi AXI read-path blocks: register-stage type
// codes, the skid-buffer state encoding and a parameter sanity helper.
package taxi_axi_pkg;

  localparam int REG_BYPASS = 0;
  localparam int REG_SIMPLE = 1;
  localparam int REG_SKID   = 2;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  function automatic bit reg_type_valid(input int reg_type);
    return (reg_type >= REG_BYPASS) && (reg_type <= REG_SKID);
  endfunction

endpackage

// File: rtl/taxi_axi_if.sv
// AXI4 read-channel bundle (AR + R). rd_slv is the view of a block that
// receives read requests; rd_mst is the view of a block that issues them.
interface taxi_axi_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 8,
  parameter bit ARUSER_EN = 1'b0,
  parameter int ARUSER_W  = 1,
  parameter bit RUSER_EN  = 1'b0,
  parameter int RUSER_W   = 1
) ();

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport rd_slv (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport rd_mst (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

endinterface

// File: rtl/taxi_axi_pipe_rd_ch.sv
// Generic valid/ready register stage used for both AR and R channels.
// REG_TYPE selects bypass wires, a single output register, or a skid buffer.
//
// Skid buffer states:
//   state      | meaning
//   SKID_EMPTY | output register empty, input ready
//   SKID_ONE   | output register holds a beat, temp empty, input ready
//   SKID_FULL  | output and temp both hold beats, input stalled
module taxi_axi_pipe_rd_ch
  import taxi_axi_pkg::*;
#(
  parameter int REG_TYPE = REG_SKID,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  if (!reg_type_valid(REG_TYPE)) begin : g_bad_type
    $fatal(1, "taxi_axi_pipe_rd_ch: REG_TYPE %0d outside 0..2", REG_TYPE);
  end

  if (REG_TYPE == REG_BYPASS) begin : g_bypass
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;

  end else if (REG_TYPE == REG_SIMPLE) begin : g_simple
    logic         valid_q;
    logic [W-1:0] data_q;

    // Occupancy bit: set on accept while empty, cleared on downstream handshake
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else if (in_valid && !valid_q) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end

    // Payload capture; not reset since valid_q qualifies it
    always_ff @(posedge clk) begin
      if (in_valid && !valid_q) begin
        data_q <= in_data;
      end
    end

    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

  end else begin : g_skid
    skid_state_t  state_q, state_d;
    logic [W-1:0] out_q, tmp_q;
    logic         in_hs, out_hs;
    logic         load_out, load_tmp, move_tmp;

    // Handshakes depend only on registered state, so no input-to-output path
    assign in_hs  = in_valid && (state_q != SKID_FULL);
    assign out_hs = out_ready && (state_q != SKID_EMPTY);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= SKID_EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Next-state logic
    always_comb begin
      state_d = state_q;
      case (state_q)
        SKID_EMPTY: if (in_hs) state_d = SKID_ONE;
        SKID_ONE: begin
          if (in_hs && !out_hs)      state_d = SKID_FULL;
          else if (!in_hs && out_hs) state_d = SKID_EMPTY;
        end
        SKID_FULL:  if (out_hs) state_d = SKID_ONE;
        default:    state_d = SKID_EMPTY;
      endcase
    end

    // Output decode: handshake flags and datapath load enables
    always_comb begin
      in_ready  = (state_q != SKID_FULL);
      out_valid = (state_q != SKID_EMPTY);
      load_out  = 1'b0;
      load_tmp  = 1'b0;
      move_tmp  = 1'b0;
      case (state_q)
        SKID_EMPTY: load_out = in_hs;
        SKID_ONE: begin
          load_out = in_hs && out_hs;
          load_tmp = in_hs && !out_hs;
        end
        SKID_FULL:  move_tmp = out_hs;
        default: ;
      endcase
    end

    // Payload registers; occupancy lives entirely in the state register
    always_ff @(posedge clk) begin
      if (load_out) begin
        out_q <= in_data;
      end else if (move_tmp) begin
        out_q <= tmp_q;
      end
      if (load_tmp) begin
        tmp_q <= in_data;
      end
    end

    assign out_data = out_q;
  end

endmodule

// File: rtl/taxi_axi_pipe_rd.sv
// AXI4 read-path register slice: one configurable stage on AR (toward the
// slave) and one on R (toward the master). Payload, ordering and IDs pass
// through untouched. User sideband is carried only when
// TAXI_AXI_PIPE_RD_USER_EN is defined and both sides enable it.
module taxi_axi_pipe_rd
  import taxi_axi_pkg::*;
#(
  parameter int AR_REG_TYPE = REG_SKID,
  parameter int R_REG_TYPE  = REG_SKID
) (
  input  logic          clk,
  input  logic          rst_n,
  taxi_axi_if.rd_slv    s_axi_rd,
  taxi_axi_if.rd_mst    m_axi_rd
);

  localparam int DATA_W   = s_axi_rd.DATA_W;
  localparam int ADDR_W   = s_axi_rd.ADDR_W;
  localparam int ID_W     = s_axi_rd.ID_W;
  localparam int ARUSER_W = s_axi_rd.ARUSER_W;
  localparam int RUSER_W  = s_axi_rd.RUSER_W;

  // AR fixed fields: len 8, size 3, burst 2, lock 1, cache 4, prot 3, qos 4, region 4
  localparam int AR_BASE_W = ID_W + ADDR_W + 29;
  localparam int R_BASE_W  = ID_W + DATA_W + 3;

  if (m_axi_rd.DATA_W != DATA_W || m_axi_rd.ADDR_W != ADDR_W ||
      m_axi_rd.ID_W != ID_W) begin : g_bad_if
    $fatal(1, "taxi_axi_pipe_rd: m_axi_rd DATA_W/ADDR_W/ID_W differ from s_axi_rd");
  end

`ifdef TAXI_AXI_PIPE_RD_USER_EN
  localparam bit AR_USER_EN = s_axi_rd.ARUSER_EN && m_axi_rd.ARUSER_EN;
  localparam bit R_USER_EN  = s_axi_rd.RUSER_EN && m_axi_rd.RUSER_EN;
  localparam int AR_W = AR_BASE_W + ARUSER_W;
  localparam int R_W  = R_BASE_W + RUSER_W;

  logic [ARUSER_W-1:0] ar_user_in, ar_user_out;
  logic [RUSER_W-1:0]  r_user_in, r_user_out;
`else
  localparam int AR_W = AR_BASE_W;
  localparam int R_W  = R_BASE_W;
`endif

  logic [AR_W-1:0] ar_in, ar_out;
  logic [R_W-1:0]  r_in, r_out;

`ifdef TAXI_AXI_PIPE_RD_USER_EN
  assign ar_user_in = AR_USER_EN ? s_axi_rd.aruser : '0;
  assign r_user_in  = R_USER_EN ? m_axi_rd.ruser : '0;

  assign ar_in = {s_axi_rd.arid, s_axi_rd.araddr, s_axi_rd.arlen, s_axi_rd.arsize,
                  s_axi_rd.arburst, s_axi_rd.arlock, s_axi_rd.arcache, s_axi_rd.arprot,
                  s_axi_rd.arqos, s_axi_rd.arregion, ar_user_in};
  assign {m_axi_rd.arid, m_axi_rd.araddr, m_axi_rd.arlen, m_axi_rd.arsize,
          m_axi_rd.arburst, m_axi_rd.arlock, m_axi_rd.arcache, m_axi_rd.arprot,
          m_axi_rd.arqos, m_axi_rd.arregion, ar_user_out} = ar_out;
  assign m_axi_rd.aruser = AR_USER_EN ? ar_user_out : '0;

  assign r_in = {m_axi_rd.rid, m_axi_rd.rdata, m_axi_rd.rresp, m_axi_rd.rlast, r_user_in};
  assign {s_axi_rd.rid, s_axi_rd.rdata, s_axi_rd.rresp, s_axi_rd.rlast, r_user_out} = r_out;
  assign s_axi_rd.ruser = R_USER_EN ? r_user_out : '0;
`else
  assign ar_in = {s_axi_rd.arid, s_axi_rd.araddr, s_axi_rd.arlen, s_axi_rd.arsize,
                  s_axi_rd.arburst, s_axi_rd.arlock, s_axi_rd.arcache, s_axi_rd.arprot,
                  s_axi_rd.arqos, s_axi_rd.arregion};
  assign {m_axi_rd.arid, m_axi_rd.araddr, m_axi_rd.arlen, m_axi_rd.arsize,
          m_axi_rd.arburst, m_axi_rd.arlock, m_axi_rd.arcache, m_axi_rd.arprot,
          m_axi_rd.arqos, m_axi_rd.arregion} = ar_out;
  assign m_axi_rd.aruser = '0;

  assign r_in = {m_axi_rd.rid, m_axi_rd.rdata, m_axi_rd.rresp, m_axi_rd.rlast};
  assign {s_axi_rd.rid, s_axi_rd.rdata, s_axi_rd.rresp, s_axi_rd.rlast} = r_out;
  assign s_axi_rd.ruser = '0;
`endif

  taxi_axi_pipe_rd_ch #(
    .REG_TYPE (AR_REG_TYPE),
    .W        (AR_W)
  ) u_ar (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (ar_in),
    .in_valid  (s_axi_rd.arvalid),
    .in_ready  (s_axi_rd.arready),
    .out_data  (ar_out),
    .out_valid (m_axi_rd.arvalid),
    .out_ready (m_axi_rd.arready)
  );

  taxi_axi_pipe_rd_ch #(
    .REG_TYPE (R_REG_TYPE),
    .W        (R_W)
  ) u_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (r_in),
    .in_valid  (m_axi_rd.rvalid),
    .in_ready  (m_axi_rd.rready),
    .out_data  (r_out),
    .out_valid (s_axi_rd.rvalid),
    .out_ready (s_axi_rd.rready)
  );

endmodule

// File: tb/tb_taxi_axi_pipe_rd.sv
// Directed bench for taxi_axi_pipe_rd: three instances (skid, simple, bypass).
module tb_taxi_axi_pipe_rd;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef TAXI_AXI_PIPE_RD_USER_EN
  localparam logic [1:0] EXP_ARUSER = 2'h3;
  localparam logic [1:0] EXP_RUSER  = 2'h2;
`else
  localparam logic [1:0] EXP_ARUSER = 2'h0;
  localparam logic [1:0] EXP_RUSER  = 2'h0;
`endif

  taxi_axi_if #(.DATA_W(32), .ADDR_W(32), .ID_W(8), .ARUSER_EN(1'b1), .ARUSER_W(2),
                .RUSER_EN(1'b1), .RUSER_W(2)) s2 (), m2 (), s1 (), m1 (), s0 (), m0 ();

  taxi_axi_pipe_rd #(.AR_REG_TYPE(2), .R_REG_TYPE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_axi_rd(s2), .m_axi_rd(m2));
  taxi_axi_pipe_rd #(.AR_REG_TYPE(1), .R_REG_TYPE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_axi_rd(s1), .m_axi_rd(m1));
  taxi_axi_pipe_rd #(.AR_REG_TYPE(0), .R_REG_TYPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_axi_rd(s0), .m_axi_rd(m0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic init_fields();
    s2.arid = '0; s2.araddr = '0; s2.arlen = 8'd0; s2.arsize = 3'd2; s2.arburst = 2'd1;
    s2.arlock = 1'b0; s2.arcache = 4'd3; s2.arprot = 3'd0; s2.arqos = 4'd0;
    s2.arregion = 4'd0; s2.aruser = '0;
    s1.arid = '0; s1.araddr = '0; s1.arlen = 8'd0; s1.arsize = 3'd2; s1.arburst = 2'd1;
    s1.arlock = 1'b0; s1.arcache = 4'd3; s1.arprot = 3'd0; s1.arqos = 4'd0;
    s1.arregion = 4'd0; s1.aruser = '0;
    s0.arid = '0; s0.araddr = '0; s0.arlen = 8'd0; s0.arsize = 3'd2; s0.arburst = 2'd1;
    s0.arlock = 1'b0; s0.arcache = 4'd3; s0.arprot = 3'd0; s0.arqos = 4'd0;
    s0.arregion = 4'd0; s0.aruser = '0;
    m2.rid = '0; m2.rdata = '0; m2.rresp = 2'd0; m2.rlast = 1'b0; m2.ruser = '0;
    m1.rid = '0; m1.rdata = '0; m1.rresp = 2'd0; m1.rlast = 1'b0; m1.ruser = '0;
    m0.rid = '0; m0.rdata = '0; m0.rresp = 2'd0; m0.rlast = 1'b0; m0.ruser = '0;
  endtask

  task automatic idle(input int n);
    s2.arvalid = 1'b0; s2.rready = 1'b1; m2.arready = 1'b1; m2.rvalid = 1'b0;
    s1.arvalid = 1'b0; s1.rready = 1'b1; m1.arready = 1'b1; m1.rvalid = 1'b0;
    s0.arvalid = 1'b0; s0.rready = 1'b1; m0.arready = 1'b1; m0.rvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_fields();
    idle(0);
    #3;
    checks++; if (m2.arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid2 got %b exp 0", m2.arvalid); end
    checks++; if (s2.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid2 got %b exp 0", s2.rvalid); end
    checks++; if (m1.arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid1 got %b exp 0", m1.arvalid); end
    checks++; if (s1.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid1 got %b exp 0", s1.rvalid); end
    #9 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (s2.arready !== 1'b1) begin errors++; $display("FAIL rst_arready2 got %b exp 1", s2.arready); end
    checks++; if (m2.rready !== 1'b1) begin errors++; $display("FAIL rst_rready2 got %b exp 1", m2.rready); end
    checks++; if (s1.arready !== 1'b1) begin errors++; $display("FAIL rst_arready1 got %b exp 1", s1.arready); end
    checks++; if (m1.rready !== 1'b1) begin errors++; $display("FAIL rst_rready1 got %b exp 1", m1.rready); end
  endtask

  task automatic test_bypass();
    s0.arvalid = 1'b1; s0.arid = 8'h3C; s0.araddr = 32'h1234_5678; m0.arready = 1'b0;
    #1;
    checks++; if (m0.arvalid !== 1'b1) begin errors++; $display("FAIL byp_arvalid got %b exp 1", m0.arvalid); end
    checks++; if (m0.arid !== 8'h3C || m0.araddr !== 32'h1234_5678) begin errors++;
      $display("FAIL byp_ar_payload got %h/%h exp 3c/12345678", m0.arid, m0.araddr); end
    checks++; if (s0.arready !== 1'b0) begin errors++; $display("FAIL byp_arready_lo got %b exp 0", s0.arready); end
    m0.arready = 1'b1;
    #1;
    checks++; if (s0.arready !== 1'b1) begin errors++; $display("FAIL byp_arready_hi got %b exp 1", s0.arready); end
    m0.rvalid = 1'b1; m0.rid = 8'h11; m0.rdata = 32'hDEAD_BEEF; m0.rlast = 1'b1; s0.rready = 1'b0;
    #1;
    checks++; if (s0.rvalid !== 1'b1 || s0.rid !== 8'h11 || s0.rdata !== 32'hDEAD_BEEF || s0.rlast !== 1'b1) begin
      errors++; $display("FAIL byp_r got v%b id%h d%h l%b exp 1/11/deadbeef/1", s0.rvalid, s0.rid, s0.rdata, s0.rlast); end
    checks++; if (m0.rready !== 1'b0) begin errors++; $display("FAIL byp_rready got %b exp 0", m0.rready); end
    idle(2);
  endtask

  task automatic test_skid_ar();
    m2.arready = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k < 16) begin
        s2.arvalid = 1'b1; s2.arid = 8'(k); s2.araddr = 32'h1000 + 32'(64 * k);
      end else begin
        s2.arvalid = 1'b0;
      end
      @(negedge clk);
      if (k < 16) begin
        checks++; if (s2.arready !== 1'b1) begin errors++; $display("FAIL skid_ar_ready k=%0d got %b exp 1", k, s2.arready); end
      end
      checks++;
      if (m2.arvalid !== (k >= 1 && k <= 16)) begin errors++;
        $display("FAIL skid_ar_valid k=%0d got %b exp %b", k, m2.arvalid, (k >= 1 && k <= 16)); end
      if (k >= 1 && k <= 16) begin
        checks++;
        if (m2.arid !== 8'(k - 1) || m2.araddr !== 32'h1000 + 32'(64 * (k - 1))) begin errors++;
          $display("FAIL skid_ar_beat k=%0d got %h/%h exp %h/%h", k, m2.arid, m2.araddr,
                   8'(k - 1), 32'h1000 + 32'(64 * (k - 1))); end
      end
    end
    idle(2);
  endtask

  task automatic test_skid_r();
    int j;
    int got;
    j = 0; got = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      s2.rready = !(k >= 4 && k <= 6);
      m2.rvalid = (j < 8); m2.rid = 8'd5; m2.rdata = 32'hA0 + 32'(j); m2.rlast = (j == 7);
      @(negedge clk);
      if (k == 4 || k == 8) begin
        checks++; if (m2.rready !== 1'b1) begin errors++; $display("FAIL skid_r_ready k=%0d got %b exp 1", k, m2.rready); end
      end
      if (k >= 5 && k <= 7) begin
        checks++; if (m2.rready !== 1'b0) begin errors++; $display("FAIL skid_r_stall k=%0d got %b exp 0", k, m2.rready); end
      end
      if (m2.rvalid && m2.rready) j++;
      if (s2.rvalid && s2.rready) begin
        checks++;
        if (s2.rdata !== 32'hA0 + 32'(got) || s2.rid !== 8'd5 || s2.rlast !== (got == 7)) begin errors++;
          $display("FAIL skid_r_beat %0d got d%h id%h l%b exp d%h id05 l%b", got, s2.rdata, s2.rid,
                   s2.rlast, 32'hA0 + 32'(got), (got == 7)); end
        got++;
      end
    end
    checks++; if (got != 8) begin errors++; $display("FAIL skid_r_count got %0d exp 8", got); end
    checks++; if (j != 8) begin errors++; $display("FAIL skid_r_sent got %0d exp 8", j); end
    idle(2);
  endtask

  task automatic test_simple();
    int j;
    int got;
    j = 0; got = 0;
    m1.arready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      s1.arvalid = 1'b1; s1.arid = 8'(j); s1.araddr = 32'h2000 + 32'(16 * j);
      @(negedge clk);
      checks++;
      if (s1.arready !== (k % 2 == 0)) begin errors++;
        $display("FAIL simple_ready k=%0d got %b exp %b", k, s1.arready, (k % 2 == 0)); end
      if (s1.arvalid && s1.arready) j++;
      if (m1.arvalid && m1.arready) begin
        checks++;
        if (m1.arid !== 8'(got) || m1.araddr !== 32'h2000 + 32'(16 * got)) begin errors++;
          $display("FAIL simple_beat %0d got %h/%h exp %h/%h", got, m1.arid, m1.araddr,
                   8'(got), 32'h2000 + 32'(16 * got)); end
        got++;
      end
    end
    checks++; if (got != 6) begin errors++; $display("FAIL simple_count got %0d exp 6", got); end
    idle(2);
  endtask

  task automatic test_user();
    @(posedge clk); #1;
    s2.arvalid = 1'b1; s2.arid = 8'h42; s2.aruser = 2'h3; m2.arready = 1'b1;
    m2.rvalid = 1'b1; m2.rid = 8'h24; m2.ruser = 2'h2; m2.rlast = 1'b1; s2.rready = 1'b1;
    s0.aruser = 2'h3;
    @(posedge clk); #1;
    s2.arvalid = 1'b0; m2.rvalid = 1'b0;
    @(negedge clk);
    checks++; if (m2.arvalid !== 1'b1 || m2.arid !== 8'h42) begin errors++;
      $display("FAIL user_ar_beat got v%b id%h exp 1/42", m2.arvalid, m2.arid); end
    checks++; if (m2.aruser !== EXP_ARUSER) begin errors++;
      $display("FAIL user_aruser got %h exp %h", m2.aruser, EXP_ARUSER); end
    checks++; if (s2.rvalid !== 1'b1 || s2.ruser !== EXP_RUSER) begin errors++;
      $display("FAIL user_ruser got v%b u%h exp 1/%h", s2.rvalid, s2.ruser, EXP_RUSER); end
    checks++; if (m0.aruser !== EXP_ARUSER) begin errors++;
      $display("FAIL user_aruser_byp got %h exp %h", m0.aruser, EXP_ARUSER); end
    s2.aruser = '0; s0.aruser = '0; m2.ruser = '0;
    idle(2);
  endtask

  task automatic test_reset_mid();
    m2.arready = 1'b0;
    @(posedge clk); #1;
    s2.arvalid = 1'b1; s2.arid = 8'h77;
    @(posedge clk); @(negedge clk);
    checks++; if (m2.arvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_arvalid got %b exp 1", m2.arvalid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (m2.arvalid !== 1'b0) begin errors++; $display("FAIL mid_async_arvalid got %b exp 0", m2.arvalid); end
    checks++; if (s2.rvalid !== 1'b0) begin errors++; $display("FAIL mid_async_rvalid got %b exp 0", s2.rvalid); end
    s2.arvalid = 1'b0; m2.arready = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (s2.arready !== 1'b1) begin errors++; $display("FAIL mid_post_arready got %b exp 1", s2.arready); end
    checks++; if (m2.arvalid !== 1'b0) begin errors++; $display("FAIL mid_post_arvalid got %b exp 0", m2.arvalid); end
    idle(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_skid_ar();
    test_skid_r();
    test_simple();
    test_user();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
